mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arb_timer.sv | 33 +++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the CPU memory path: data width, the word-size
// funct3 code and the arbiter FSM state encodings. The CPU core imports the
// same package so both sides agree on the encodings.
package mem_arbiter_pkg;

    localparam int unsigned XLEN = 32;

    // funct3 code for a full 32-bit word access (LW/SW); fetches always use it
    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Transaction timeout counter for mem_arbiter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the count (takes priority over en)
//   en         : count this cycle (transaction outstanding, no completion)
//   limit      : number of counted cycles that constitutes a timeout
//   expired    : high in the cycle whose count reaches limit
module mem_arb_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] limit,
    output logic        expired
);

    logic [31:0] cnt;

    // cnt holds the cycles already counted; the current enabled cycle is the
    // (cnt+1)-th, so the timeout fires in the limit-th waiting cycle itself.
    assign expired = en && ((cnt + 32'd1) == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between the CPU instruction-fetch port, the CPU data port and a
// single unified memory. Data wins contention unless the fetch port has
// been passed over STARVE_LIMIT times in a row. A request that sees no
// m_ack for TIMEOUT cycles is terminated with a one-cycle err.
// Ports:
//   clk, rst_n                              : clock, async active-low reset
//   i_req/i_addr -> i_ack/i_err/i_rdata     : fetch port (read-only)
//   d_req/d_we/d_addr/d_wdata/d_funct3
//                -> d_ack/d_err/d_rdata     : data port
//   m_req/m_we/m_addr/m_wdata/m_funct3      : registered memory request
//   m_ack/m_rdata                           : memory completion and read data
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_ack,
    output logic            i_err,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [2:0]      d_funct3,
    output logic            d_ack,
    output logic            d_err,
    output logic [XLEN-1:0] d_rdata,
    output logic            m_req,
    output logic            m_we,
    output logic [XLEN-1:0] m_addr,
    output logic [XLEN-1:0] m_wdata,
    output logic [2:0]      m_funct3,
    input  logic            m_ack,
    input  logic [XLEN-1:0] m_rdata
);

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    arb_state_t state;
    logic [2:0] starve_cnt;
    logic       busy;
    logic       tmo_en;
    logic       tmo_clr;
    logic       tmo_expired;
    logic       done;
    logic       grant_i;
    logic       grant_d;

    assign busy    = (state == BUSY_I) || (state == BUSY_D);
    // The timer only counts cycles without m_ack, so completion in the
    // timeout cycle suppresses expiry and the ack wins.
    assign tmo_en  = busy && !m_ack;
    assign done    = busy && (m_ack || tmo_expired);
    assign tmo_clr = !busy || done;

    mem_arb_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .limit   (32'(TIMEOUT)),
        .expired (tmo_expired)
    );

    // Data has priority; fetch overrides once it has been starved long enough.
    assign grant_i = i_req && (!d_req || (starve_cnt == STARVE_MAX));
    assign grant_d = d_req && !grant_i;

    // Responses are combinational from m_ack so the requester sees its
    // completion in the same cycle the memory does.
    assign i_ack   = (state == BUSY_I) && m_ack;
    assign d_ack   = (state == BUSY_D) && m_ack;
    assign i_err   = (state == BUSY_I) && tmo_expired;
    assign d_err   = (state == BUSY_D) && tmo_expired;
    assign i_rdata = i_ack ? m_rdata : '0;
    assign d_rdata = d_ack ? m_rdata : '0;

    // FSM with registered memory-side outputs: no path from any *_req to m_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_funct3   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state      <= BUSY_I;
                        m_req      <= 1'b1;
                        m_we       <= 1'b0;
                        m_addr     <= i_addr;
                        m_wdata    <= '0;
                        m_funct3   <= FUNCT3_WORD;
                        starve_cnt <= '0;
                    end else if (grant_d) begin
                        state    <= BUSY_D;
                        m_req    <= 1'b1;
                        m_we     <= d_we;
                        m_addr   <= d_addr;
                        m_wdata  <= d_wdata;
                        m_funct3 <= d_funct3;
                        // Only a grant that actually passed over a waiting
                        // fetch counts toward starvation.
                        if (i_req && (starve_cnt != STARVE_MAX))
                            starve_cnt <= starve_cnt + 3'd1;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (done) begin
                        state <= IDLE;
                        m_req <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants/responses are queued in
// grant order when stimulus is issued and checked as the DUT produces them.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int TMO = 255;

    logic        clk, rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack, i_err;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [2:0]  d_funct3;
    logic        d_ack, d_err;
    logic [31:0] d_rdata;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [2:0]  m_funct3;
    logic        m_ack;
    logic [31:0] m_rdata;

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_funct3(m_funct3),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit          is_i;
        bit          err;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   mem_lat  = 0;   // wait cycles before m_ack; -1 = never
    bit   spur_ack = 0;

    task automatic push(input bit is_i, input bit err, input logic we,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3);
        exp_t e;
        e.is_i  = is_i;
        e.err   = err;
        e.we    = is_i ? 1'b0 : we;
        e.addr  = addr;
        e.wdata = is_i ? 32'h0 : wd;
        e.f3    = is_i ? 3'b010 : f3;
        e.cyc   = err ? TMO : mem_lat + 1;
        exp_q.push_back(e);
    endtask

    // Memory model: ack after mem_lat wait cycles, data = addr + 3.
    int mcyc = 0;
    initial begin
        m_ack = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (m_req && rst_n) mcyc++;
            else mcyc = 0;
            m_ack = spur_ack || (m_req && mem_lat >= 0 && mcyc == mem_lat + 1);
            m_rdata = m_ack ? m_addr + 32'd3 : $urandom;
        end
    end

    // Monitor: checks grants, bus stability, responses, idle gap.
    initial begin
        logic        pm_req;
        bit          done_prev;
        int          busy_n;
        logic [31:0] la, lw;
        logic        lwe;
        logic [2:0]  lf;
        exp_t        e;
        pm_req = 0; done_prev = 0; busy_n = 0;
        la = '0; lw = '0; lwe = 0; lf = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pm_req = 0; done_prev = 0; busy_n = 0;
            end else begin
                if (done_prev) chk("idle_gap", 32'(m_req), 32'd0);
                if (m_req && !pm_req) begin
                    busy_n = 1;
                    if (exp_q.size() == 0) chk("grant_unexpected", 32'd1, 32'd0);
                    else begin
                        chk("m_addr", m_addr, exp_q[0].addr);
                        chk("m_wdata", m_wdata, exp_q[0].wdata);
                        chk("m_we_f3", {28'd0, m_we, m_funct3}, {28'd0, exp_q[0].we, exp_q[0].f3});
                    end
                end else if (m_req) begin
                    busy_n++;
                    chk("m_addr_stable", m_addr, la);
                    chk("m_wdata_stable", m_wdata, lw);
                    chk("m_ctl_stable", {28'd0, m_we, m_funct3}, {28'd0, lwe, lf});
                end
                la = m_addr; lw = m_wdata; lwe = m_we; lf = m_funct3;
                if (i_ack || d_ack || i_err || d_err) begin
                    if (exp_q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk("resp_flags", {28'd0, i_ack, i_err, d_ack, d_err},
                            {28'd0, e.is_i && !e.err, e.is_i && e.err, !e.is_i && !e.err, !e.is_i && e.err});
                        chk("i_rdata", i_rdata, (e.is_i && !e.err) ? e.addr + 32'd3 : 32'd0);
                        chk("d_rdata", d_rdata, (!e.is_i && !e.err) ? e.addr + 32'd3 : 32'd0);
                        chk("resp_cycles", 32'(busy_n), 32'(e.cyc));
                    end
                    done_prev = 1;
                end else begin
                    done_prev = 0;
                    chk("rdata_idle", i_rdata | d_rdata, 32'd0);
                end
                pm_req = m_req;
            end
        end
    end

    // Requesters: called just after a rising edge; return just after the
    // rising edge that follows the response.
    task automatic req_i(input logic [31:0] a, input bit keep);
        bit got;
        i_req = 1; i_addr = a;
        got = 0;
        for (int n = 0; n < 1000 && !got; n++) begin
            @(negedge clk);
            got = i_ack || i_err;
        end
        if (!got) chk("i_wait_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (!keep) begin i_req = 0; i_addr = '0; end
    endtask

    task automatic req_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, input bit keep);
        bit got;
        d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_funct3 = f3;
        got = 0;
        for (int n = 0; n < 1000 && !got; n++) begin
            @(negedge clk);
            got = d_ack || d_err;
        end
        if (!got) chk("d_wait_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (!keep) begin d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_funct3 = '0; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1);
    end

    initial begin
        rst_n = 0;
        i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_funct3 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_req_we", {30'd0, m_req, m_we}, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_m_funct3", 32'(m_funct3), 32'd0);
        chk("rst_ack_err", {28'd0, i_ack, i_err, d_ack, d_err}, 32'd0);
        chk("rst_rdata", i_rdata | d_rdata, 32'd0);
        rst_n = 1;
        @(posedge clk); #1;

        // Fetch only, memory answers on the third m_req cycle.
        mem_lat = 2;
        push(1, 0, 0, 32'h10, 0, 0);
        fork
            req_i(32'h0000_0010, 0);
            begin @(posedge clk); @(negedge clk); chk("first_latency_m_req", 32'(m_req), 32'd1); end
        join

        // Simultaneous requests: data first, then fetch.
        mem_lat = 1;
        push(0, 0, 1, 32'h100, 32'hDEAD_BEEF, 3'b010);
        push(1, 0, 0, 32'h200, 0, 0);
        fork
            req_d(1, 32'h100, 32'hDEAD_BEEF, 3'b010, 0);
            req_i(32'h200, 0);
        join

        // Starvation: four data grants, then the fetch, then the remaining data.
        mem_lat = 0;
        for (int k = 0; k < 4; k++) push(0, 0, 0, 32'h300 + 32'(4 * k), 0, 3'b010);
        push(1, 0, 0, 32'h400, 0, 0);
        push(0, 0, 0, 32'h310, 0, 3'b010);
        fork
            begin
                req_i(32'h400, 0);
                chk("starve_cnt_cleared", 32'(dut.starve_cnt), 32'd0);
            end
            for (int k = 0; k < 5; k++) req_d(0, 32'h300 + 32'(4 * k), 0, 3'b010, k < 4);
        join

        // m_ack while idle must be ignored.
        @(negedge clk); spur_ack = 1;
        @(negedge clk);
        chk("spur_ack_resp", {28'd0, i_ack, i_err, d_ack, d_err}, 32'd0);
        spur_ack = 0;
        @(negedge clk);
        chk("spur_ack_m_req", 32'(m_req), 32'd0);
        @(posedge clk); #1;

        // Data timeout, then fetch timeout.
        mem_lat = -1;
        push(0, 1, 1, 32'h500, 32'h1234_5678, 3'b001);
        req_d(1, 32'h500, 32'h1234_5678, 3'b001, 0);
        chk("tmo_state_idle", 32'(dut.state), 32'(IDLE));
        push(1, 1, 0, 32'h600, 0, 0);
        req_i(32'h600, 0);

        // Completion in the timeout cycle wins.
        mem_lat = TMO - 1;
        push(0, 0, 0, 32'h700, 0, 3'b010);
        req_d(0, 32'h700, 0, 3'b010, 0);

        // Short random sequential traffic on both ports.
        for (int k = 0; k < 6; k++) begin
            logic [31:0] a, wd;
            logic        we;
            a = {$urandom_range(0, 32'h3FFF), 2'b00};
            wd = $urandom;
            we = 1'($urandom_range(0, 1));
            mem_lat = $urandom_range(0, 3);
            if (k % 2 == 0) begin
                push(1, 0, 0, a, 0, 0);
                req_i(a, 0);
            end else begin
                push(0, 0, we, a, wd, 3'b000);
                req_d(we, a, wd, 3'b000, 0);
            end
        end

        // Reset in the middle of a data transaction, then reissue.
        mem_lat = -1;
        push(0, 0, 1, 32'h800, 32'hCAFE_F00D, 3'b010);
        d_req = 1; d_we = 1; d_addr = 32'h800; d_wdata = 32'hCAFE_F00D; d_funct3 = 3'b010;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("midrst_m_req", 32'(m_req), 32'd0);
        chk("midrst_d_ack_err", {30'd0, d_ack, d_err}, 32'd0);
        chk("midrst_state", 32'(dut.state), 32'(IDLE));
        exp_q.delete();
        d_req = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        mem_lat = 1;
        push(0, 0, 1, 32'h800, 32'hCAFE_F00D, 3'b010);
        req_d(1, 32'h800, 32'hCAFE_F00D, 3'b010, 0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
